// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM slot arbiter
//
// Provides the arbiter state encoding, the issued-command and read-tag
// records, the port index constants and the round-robin pick helper.
package sdram_arb_pkg;

    // Default SDRAM byte address width; the command record is sized by it.
    localparam int SD_ADDR_W = 21;

    localparam logic PORT_TESTER = 1'b0;
    localparam logic PORT_HOST   = 1'b1;

    typedef enum logic {
        WAIT_RDY = 1'b0,
        RUN      = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 we;
        logic                 aux;
        logic [SD_ADDR_W-1:0] addr;
        logic [7:0]           din;
    } sd_cmd_t;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    // On a tie the port that was not granted last wins.
    function automatic logic rr_pick(input logic last_port);
        return ~last_port;
    endfunction

endpackage

// File: rtl/rd_return_pipe.sv
// rtl/rd_return_pipe.sv - read-return tag shift register with flush
//
// Ports:
//   clk, rst_n          slot clock, asynchronous active-low reset
//   flush               clear every stage on the next edge (takes priority)
//   in_valid, in_port   tag of the read the controller samples this slot
//   out_valid, out_port tag whose data sd_dout holds this slot
//   busy                OR of all stage valid bits
module rd_return_pipe
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  logic in_port,
    output logic out_valid,
    output logic out_port,
    output logic busy
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0].valid <= in_valid;
            stage[0].port  <= in_port;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_valid = stage[DEPTH-1].valid;
    assign out_port  = stage[DEPTH-1].port;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            busy = busy | stage[i].valid;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// rtl/sdram_slot_arbiter.sv - two-port round-robin arbiter for the SDRAM slot port
//
// Ports:
//   clk14M, rst          slot clock, asynchronous active-low reset
//   ready                SDRAM initialised; traffic is held off while low
//   req*/we*/aux*/addr*/din*  requester 0 (pattern tester) and 1 (host engine)
//   gnt*                 one-cycle pulse: request issued this slot
//   rvalid*/rdata*       read data return, rdata held between pulses
//   sd_addr/sd_din/sd_we/sd_aux  issue register toward the controller
//   sd_dout              read data from the controller
//   busy                 read return pipeline not empty
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = SD_ADDR_W
) (
    input  logic              clk14M,
    input  logic              rst,
    input  logic              ready,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              aux0,
    input  logic              aux1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        din0,
    input  logic [7:0]        din1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [15:0]       rdata0,
    output logic [15:0]       rdata1,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [7:0]        sd_din,
    output logic              sd_we,
    output logic              sd_aux,
    input  logic [15:0]       sd_dout,
    output logic              busy
);

    arb_state_t state;
    arb_state_t state_nxt;

    logic    last;
    logic    pick0;
    logic    pick1;
    logic    flush;
    sd_cmd_t cmd_sel;

    logic    pipe_out_valid;
    logic    pipe_out_port;
    logic    ret_valid;

    // State register
    always_ff @(posedge clk14M or negedge rst) begin
        if (!rst) begin
            state <= WAIT_RDY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_RDY: if (ready)  state_nxt = RUN;
            RUN:      if (!ready) state_nxt = WAIT_RDY;
            default:  state_nxt = WAIT_RDY;
        endcase
    end

    // Output logic: grant selection and pipeline flush.
    // Grants also require ready so the slot in which ready drops issues nothing.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        flush = !ready;
        if (state == RUN && ready) begin
            if (req0 && req1) begin
                if (rr_pick(last) == PORT_TESTER) pick0 = 1'b1;
                else                              pick1 = 1'b1;
            end else if (req0) begin
                pick0 = 1'b1;
            end else if (req1) begin
                pick1 = 1'b1;
            end
        end
    end

    always_comb begin
        cmd_sel.we   = pick1 ? we1  : we0;
        cmd_sel.aux  = pick1 ? aux1 : aux0;
        cmd_sel.addr = pick1 ? SD_ADDR_W'(addr1) : SD_ADDR_W'(addr0);
        cmd_sel.din  = pick1 ? din1 : din0;
    end

    // Issue register. Idle slots drop sd_we and keep address/data, so the
    // controller sees a harmless read of the last address.
    always_ff @(posedge clk14M or negedge rst) begin
        if (!rst) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            sd_we   <= 1'b0;
            sd_aux  <= 1'b0;
            sd_addr <= '0;
            sd_din  <= '0;
            last    <= PORT_HOST;
        end else begin
            gnt0 <= pick0;
            gnt1 <= pick1;
            if (pick0 || pick1) begin
                sd_we   <= cmd_sel.we;
                sd_aux  <= cmd_sel.aux;
                sd_addr <= ADDR_W'(cmd_sel.addr);
                sd_din  <= cmd_sel.din;
                last    <= pick1;
            end else begin
                sd_we <= 1'b0;
            end
        end
    end

    // The tag enters the pipe in the slot the controller samples the read,
    // so after RD_LAT stages it lines up with the slot sd_dout holds the data.
    rd_return_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_return_pipe (
        .clk       (clk14M),
        .rst_n     (rst),
        .flush     (flush),
        .in_valid  ((gnt0 || gnt1) && !sd_we),
        .in_port   (gnt1),
        .out_valid (pipe_out_valid),
        .out_port  (pipe_out_port),
        .busy      (busy)
    );

    assign ret_valid = pipe_out_valid && !flush;

    always_ff @(posedge clk14M or negedge rst) begin
        if (!rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= ret_valid && (pipe_out_port == PORT_TESTER);
            rvalid1 <= ret_valid && (pipe_out_port == PORT_HOST);
            if (ret_valid) begin
                if (pipe_out_port == PORT_HOST) rdata1 <= sd_dout;
                else                            rdata0 <= sd_dout;
            end
        end
    end

endmodule
